// File: rtl/astro_uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// astro_uart_pkg : shared UART code-link types and constants   | rev 1.0
// ---------------------------------------------------------------------------
package astro_uart_pkg;

  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] STOP_CODE_DEFAULT = 5'b11111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } uart_state_e;

  // A byte carries a code only when every bit above the code field is clear.
  function automatic logic is_code_byte(input logic [7:0] b);
    return (b[7:CODE_W] == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// rx_sync2 : two-flop synchronizer for an idle-high serial line   | rev 1.0
// ---------------------------------------------------------------------------
module rx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_code_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// uart_code_rx : 8N1 receiver that extracts 5-bit codes from bytes | rev 1.0
// ---------------------------------------------------------------------------
module uart_code_rx
  import astro_uart_pkg::*;
#(
  parameter int                CLKS_PER_BIT = 434,
  parameter logic [CODE_W-1:0] STOP_CODE    = STOP_CODE_DEFAULT
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              rx,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              stop_det,
  output logic              frame_err,
  output logic              busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(8);

  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(7);

  logic              rx_s;
  uart_state_e       state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [7:0]        shift;
  logic              stop_ok;

  rx_sync2 u_sync (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      stop_ok    <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      stop_det   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      stop_det   <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          // Level-sensitive on purpose: a held-low break restarts framing at once.
          if (!rx_s) begin
            state    <= START;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            busy     <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt       <= '0;
            shift[bit_cnt] <= rx_s;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            stop_ok  <= rx_s;
            state    <= DONE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (stop_ok && is_code_byte(shift)) begin
            code       <= shift[CODE_W-1:0];
            code_valid <= 1'b1;
            stop_det   <= (shift[CODE_W-1:0] == STOP_CODE);
          end else begin
            frame_err  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_code_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_code_rx : scoreboard bench for uart_code_rx              | rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_code_rx;

  localparam int         CPB      = 8;
  localparam logic [4:0] STOP_VAL = 5'h1F;

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [4:0] code;
  logic       code_valid;
  logic       stop_det;
  logic       frame_err;
  logic       busy;

  uart_code_rx #(
    .CLKS_PER_BIT (CPB),
    .STOP_CODE    (STOP_VAL)
  ) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .rx         (rx),
    .code       (code),
    .code_valid (code_valid),
    .stop_det   (stop_det),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct {
    bit         good;
    logic [4:0] code;
    bit         stop;
    int         stop_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  logic [4:0] model_code  = '0;

  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Drives one 8N1 frame starting at a falling clock edge; the expected
  // outcome is queued when the stop bit goes out.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int gap);
    exp_t       e;
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        e.good     = stop_bit && (b < 8'd32);
        e.code     = 5'(b % 32);
        e.stop     = e.good && (e.code == STOP_VAL);
        e.stop_cyc = cyc;
        exp_q.push_back(e);
      end
      rx = bits[i];
      repeat (CPB) @(negedge clk_50M);
    end
    rx = 1'b1;
    repeat (gap) @(negedge clk_50M);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * CPB) begin
      @(negedge clk_50M);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d outcomes still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_50M);
      if (!rst_n) begin
        model_code = '0;
        continue;
      end
      if (code_valid && frame_err) check("valid_err_exclusive", 1, 0);
      if (code_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: code_valid=%0b frame_err=%0b, required no pulse",
                   code_valid, frame_err);
        end else begin
          e = exp_q.pop_front();
          check("code_valid", code_valid, e.good);
          check("frame_err", frame_err, !e.good);
          check("stop_det", stop_det, e.stop);
          if (e.good) begin
            check("code", code, e.code);
            model_code = e.code;
          end else begin
            check("code_hold_on_err", code, model_code);
          end
          vectors++;
          if (cyc - e.stop_cyc < CPB / 2 || cyc - e.stop_cyc > CPB + 3) begin
            miscompares++;
            $display("FAIL pulse_latency: %0d cycles after stop bit start, required %0d..%0d",
                     cyc - e.stop_cyc, CPB / 2, CPB + 3);
          end
        end
      end else begin
        if (stop_det) check("stop_det_alone", stop_det, 0);
        if (code !== model_code) check("code_hold", code, model_code);
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    bit         sb;
    bit         seen;
    int         k;

    rst_n = 1'b0;
    rx    = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk_50M);
    check("rst_code", code, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_stop_det", stop_det, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_50M);
    check("post_rst_busy", busy, 0);

    // Directed frames.
    send_frame(8'h0A, 1'b1, CPB);
    drain();
    check("code_0A", code, 5'h0A);
    send_frame(8'h1F, 1'b1, CPB);
    drain();
    check("code_1F", code, 5'h1F);
    send_frame(8'h0A, 1'b0, 2 * CPB);
    drain();
    check("code_kept_after_bad_stop", code, 5'h1F);
    send_frame(8'hE3, 1'b1, CPB);
    drain();
    check("code_kept_after_E3", code, 5'h1F);

    // Short low glitch must be rejected at the start-bit check.
    rx = 1'b0;
    repeat (3) @(negedge clk_50M);
    rx = 1'b1;
    check("glitch_busy_seen", busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_50M);
      if (!busy) seen = 1'b1;
    end
    check("glitch_busy_clear", seen, 1);
    repeat (2 * CPB) @(negedge clk_50M);

    // Randomized frames, including back-to-back good frames.
    for (int n = 0; n < 28; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) b = b % 32;
      if ($urandom_range(0, 5) == 0) b = 8'h1F;
      sb = ($urandom_range(0, 3) != 0);
      if (sb) send_frame(b, sb, $urandom_range(0, 2 * CPB));
      else    send_frame(b, sb, $urandom_range(CPB, 2 * CPB));
    end
    drain();

    // Two frames back-to-back, then reset in the middle of a third.
    send_frame(8'h05, 1'b1, 0);
    send_frame(8'h1F, 1'b1, 0);
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (CPB) @(negedge clk_50M);
      rx = 1'($urandom_range(0, 1));
    end
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_last_code", code, 5'h1F);
    check("busy_mid_frame", busy, 1);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check("async_rst_code", code, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_pulses", {code_valid, stop_det, frame_err}, 0);
    repeat (2) @(negedge clk_50M);
    rst_n = 1'b1;
    k = 0;
    repeat (12 * CPB) begin
      @(negedge clk_50M);
      if (busy) k++;
    end
    check("post_abort_busy_cycles", k, 0);
    check("post_abort_code", code, 0);
    check("post_abort_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_code_rx.md
UART_CODE_RX -- requirements
Module: uart_code_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk_50M cycles per UART bit (115200 baud at 50 MHz); legal range 4..1023.
REQ-002 SHALL have parameter STOP_CODE, default 5'b11111, meaning the code value that signals end of run.
REQ-003 SHALL have port clk_50M  input  1  the single system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx  input  1  serial line, asynchronous to clk_50M, idle high, 8N1, LSB first.
REQ-006 SHALL have port code  output  5  last accepted code, taken from byte[4:0].
REQ-007 SHALL have port code_valid  output  1  one-cycle pulse when code is updated.
REQ-008 SHALL have port stop_det  output  1  one-cycle pulse, coincident with code_valid, when the accepted code equals STOP_CODE.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit or a nonzero byte[7:5].
REQ-010 SHALL have port busy  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, DONE.
REQ-013 IDLE: on rx_s low, SHALL go to START and clear the bit counter.
REQ-014 START: after CLKS_PER_BIT/2 cycles (integer divide), SHALL sample rx_s; if low, go to DATA; if high (glitch), return to IDLE with no output pulse.
REQ-015 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles into shift-register bit index 0..7, LSB first; after the 8th sample, go to STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, SHALL sample rx_s, go to DONE, and record stop_ok = rx_s.
REQ-017 DONE: lasts exactly one cycle, then IDLE; in it, the block SHALL pulse exactly one outcome:
- stop_ok=1 and byte[7:5]==0: update code, pulse code_valid, and pulse stop_det if the code equals STOP_CODE.
- otherwise: pulse frame_err only; code holds its value.
REQ-018 Latency SHALL be exactly 1 clk_50M cycle from the stop-bit sample edge to the output pulse, plus 2 cycles of synchronizer delay on rx.
REQ-019 code SHALL hold its value between valid pulses.
REQ-020 Back-to-back frames (start bit immediately after the stop bit) SHALL be received without loss, because IDLE is re-entered at the middle of the stop bit.
REQ-021 A break (rx held low) SHALL produce one frame_err per frame time.
REQ-022 code_valid and frame_err SHALL never be high in the same cycle.
REQ-023 Bit and baud counters SHALL be sized with $clog2 of their maximum counts; the baud counter SHALL reload to 0 on each sample.

Reset
REQ-024 On rst_n low, asynchronously and regardless of the current state, the block SHALL set:
- FSM to IDLE;
- counters and shift register to 0;
- synchronizer flops to 1;
- code to 5'b00000;
- code_valid, stop_det, frame_err and busy to 0.
REQ-025 Reset deassertion mid-frame SHALL leave the block waiting for the next falling edge; the partial frame is discarded and produces no pulse.

Structure
REQ-026 The state enum, STOP_CODE default and code width (5) SHALL reside in shared package astro_uart_pkg, which the transmit side also uses.
REQ-027 The synchronizer SHALL be sub-module rx_sync2 (2 flops, reset value 1); all other logic stays in uart_code_rx.

Verification (CLKS_PER_BIT=8 in all scenarios)
REQ-028 Send byte 8'h0A with a valid stop bit -> code=5'h0A, one code_valid pulse, stop_det=0, frame_err=0.
REQ-029 Send 8'h1F -> code=5'h1F, with code_valid and stop_det high in the same single cycle.
REQ-030 Send 8'h0A with stop bit low -> frame_err pulse; code unchanged from its previous value; no code_valid.
REQ-031 Send 8'hE3 -> frame_err pulse; no code_valid.
REQ-032 Send a 3-cycle low glitch on rx -> no pulses; busy returns to 0 within 6 cycles.
REQ-033 Send 8'h05 then 8'h1F back-to-back, then assert rst_n low mid-way through a third frame -> two code_valid pulses, then all outputs 0 and code=0.
